// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter: round-robin arbiter driving a shared PIPO register's load/p_in; `PIPO_ARB_LOCK_EN adds a per-requester lock input
module pipo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int HOLD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
`ifdef PIPO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     load,
  output logic [WIDTH-1:0]         p_in,
  output logic [2:0]               owner,
  output logic                     owner_vld,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, LOAD, HLD} state_t;
  localparam logic [3:0] HM1 = 4'(HOLD == 0 ? 0 : HOLD - 1);
  state_t state;
  logic [2:0] rr_ptr, win, win_r, idx;
  logic [3:0] cnt;
  logic [NUM_REQ-1:0] elig;
  logic lk_cap;
`ifdef PIPO_ARB_LOCK_EN
  logic locked, lk_hit;
  logic [2:0] lk_id;
  assign elig   = locked ? (req & (NUM_REQ'(1) << lk_id)) : req;
  assign lk_hit = |(lock & (NUM_REQ'(1) << win));
`else
  assign elig = req;
`endif
  // first eligible requester searching upward from rr_ptr with wrap
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 3'((int'(rr_ptr) + k) % NUM_REQ);
      win = |(elig & (NUM_REQ'(1) << idx)) ? idx : win;
    end
  end
  // IDLE -> LOAD -> HOLD -> IDLE with every output registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load      <= 1'b0;
      p_in      <= '0;
      gnt       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      cnt       <= '0;
      win_r     <= '0;
      lk_cap    <= 1'b0;
`ifdef PIPO_ARB_LOCK_EN
      locked    <= 1'b0;
      lk_id     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|elig) begin
          state <= LOAD;
          p_in  <= WIDTH'(wdata >> (int'(win) * WIDTH));
          load  <= 1'b1;
          gnt   <= NUM_REQ'(1) << win;
          busy  <= 1'b1;
          win_r <= win;
`ifdef PIPO_ARB_LOCK_EN
          lk_cap <= lk_hit;
          locked <= lk_hit;
          lk_id  <= win;
`endif
        end
        LOAD: begin
          load      <= 1'b0;
          gnt       <= '0;
          owner     <= win_r;
          owner_vld <= 1'b1;
          rr_ptr    <= lk_cap ? rr_ptr : 3'((int'(win_r) + 1) % NUM_REQ);
          cnt       <= '0;
          state     <= (HOLD == 0) ? IDLE : HLD;
          busy      <= (HOLD != 0);
        end
        HLD: begin
          state <= (cnt == HM1) ? IDLE : HLD;
          busy  <= (cnt != HM1);
          cnt   <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipo_write_arbiter.sv
// tb_pipo_write_arbiter: table-driven check of arbitration, hold spacing, reset and optional lock
module tb_pipo_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [15:0] wdata;
  logic [3:0] gnt;
  logic load;
  logic [3:0] p_in;
  logic [2:0] owner;
  logic owner_vld, busy;
  logic [3:0] p_out;
  logic [3:0] g;
  int errors = 0;
  int checks = 0;
`ifdef PIPO_ARB_LOCK_EN
  logic [3:0] lock;
`endif

  always #5 clk = ~clk;

  pipo_write_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
`ifdef PIPO_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .load(load), .p_in(p_in), .owner(owner),
    .owner_vld(owner_vld), .busy(busy)
  );

  // downstream PIPO register
  always @(posedge clk) p_out <= rst ? 4'h0 : (load ? p_in : p_out);

  typedef struct {
    logic [3:0] req;
    logic       ld;
    logic [3:0] g;
    logic [3:0] pi;
    logic [2:0] own;
    logic       vld;
    logic       bsy;
    logic [3:0] po;
  } vec_t;
  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [3:0] gg);
    gg = '0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (gnt != 0) begin
        gg = gnt;
        return;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 4'hA, 3'd0, 1'b0, 1'b1, 4'h0};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[2]  = '{4'b0010, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b0, 4'hA};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b0, 4'hA};
    tbl[5]  = '{4'b1111, 1'b1, 4'b1000, 4'hD, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b1, 4'hD};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b1, 4'hD};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b0, 4'hD};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 4'h3, 3'd3, 1'b1, 1'b1, 4'hD};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 4'h3, 3'd0, 1'b1, 1'b1, 4'h3};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 4'h3, 3'd0, 1'b1, 1'b1, 4'h3};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000, 4'h3, 3'd0, 1'b1, 1'b0, 4'h3};
    tbl[13] = '{4'b1111, 1'b1, 4'b0010, 4'h5, 3'd0, 1'b1, 1'b1, 4'h3};
    tbl[14] = '{4'b1111, 1'b0, 4'b0000, 4'h5, 3'd1, 1'b1, 1'b1, 4'h5};
    tbl[15] = '{4'b1111, 1'b0, 4'b0000, 4'h5, 3'd1, 1'b1, 1'b1, 4'h5};
    tbl[16] = '{4'b1111, 1'b0, 4'b0000, 4'h5, 3'd1, 1'b1, 1'b0, 4'h5};
    tbl[17] = '{4'b1111, 1'b1, 4'b0100, 4'hA, 3'd1, 1'b1, 1'b1, 4'h5};
    tbl[18] = '{4'b1111, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[19] = '{4'b1111, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[20] = '{4'b1111, 1'b0, 4'b0000, 4'hA, 3'd2, 1'b1, 1'b0, 4'hA};
    tbl[21] = '{4'b1111, 1'b1, 4'b1000, 4'hD, 3'd2, 1'b1, 1'b1, 4'hA};
    tbl[22] = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b1, 4'hD};
    tbl[23] = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b1, 4'hD};
    tbl[24] = '{4'b1111, 1'b0, 4'b0000, 4'hD, 3'd3, 1'b1, 1'b0, 4'hD};
    tbl[25] = '{4'b1111, 1'b1, 4'b0001, 4'h3, 3'd3, 1'b1, 1'b1, 4'hD};

    rst = 1'b1;
    req = 4'b1111;
    wdata = 16'hDA53;
`ifdef PIPO_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    step();
    step();
    chk("reset_state", {28'd0, load, gnt, owner_vld, busy, owner, p_in}, 32'd0);
    rst = 1'b0;
    step();
    chk("first_gnt", {27'd0, load, gnt}, {27'd0, 1'b1, 4'b0001});
    step();
    step();
    step();
    step();
    chk("second_gnt", {28'd0, gnt}, 32'b0010);
    rst = 1'b1;
    step();
    chk("rst_in_load", {25'd0, gnt, load, owner_vld, busy}, 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    step();
    chk("post_rst_idle", {26'd0, gnt, busy, owner_vld}, 32'd0);
    req = 4'b1111;
    step();
    chk("rr_after_rst", {28'd0, gnt}, 32'b0001);

    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      req = tbl[i].req;
      step();
      chk($sformatf("vec%0d", i),
          {14'd0, load, gnt, p_in, owner, owner_vld, busy, p_out},
          {14'd0, tbl[i].ld, tbl[i].g, tbl[i].pi, tbl[i].own, tbl[i].vld, tbl[i].bsy, tbl[i].po});
    end

`ifdef PIPO_ARB_LOCK_EN
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    lock = 4'b0001;
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      chk($sformatf("lock_hold%0d", i), {28'd0, g}, 32'b0001);
    end
    lock = 4'b0000;
    wait_gnt(g);
    chk("lock_release_write", {28'd0, g}, 32'b0001);
    wait_gnt(g);
    chk("after_release", {28'd0, g}, 32'b0010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
